// File: rtl/pifo_calendar_ctrl_pkg.sv
// Shared definitions for the root PIFO calendar sequencing controller:
// element field layout, FSM encoding and the element pack helper.
package pifo_calendar_ctrl_pkg;

    localparam int ELEM_MAX_W     = 64;
    localparam int ELEM_IDX_W     = 6;
    localparam int ELEM_VALID_POS = 31;
    localparam int ELEM_OVF_POS   = 30;
    localparam int ELEM_RANK_POS  = 12;
    localparam int ELEM_RANK_W    = 18;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Builds a calendar element in a 64-bit scratch word; caller truncates.
    function automatic logic [ELEM_MAX_W-1:0] pack_elem(
        input logic [ELEM_MAX_W-1:0] rank,
        input logic [ELEM_MAX_W-1:0] addr,
        input int                    rank_pos,
        input int                    rank_w,
        input int                    addr_w,
        input int                    valid_pos,
        input int                    ovf_pos
    );
        logic [ELEM_MAX_W-1:0] e;
        int j;
        int vp;
        int op;
        e  = '0;
        vp = valid_pos;
        op = ovf_pos;
        for (int i = 0; i < ELEM_MAX_W; i++) begin
            j = i - rank_pos;
            if (i < addr_w) begin
                e[i] = addr[i];
            end
            if (i >= rank_pos && i < rank_pos + rank_w) begin
                e[i] = rank[j[ELEM_IDX_W-1:0]];
            end
        end
        e[op[ELEM_IDX_W-1:0]] = 1'b0;
        e[vp[ELEM_IDX_W-1:0]] = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/pifo_ctrl_enq_fifo.sv
// Small synchronous FIFO holding enqueue descriptors ahead of the calendar.
// Clear has priority over any write or read in the same cycle.
module pifo_ctrl_enq_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr   = wr_en & ~full & ~clr;
    assign do_rd   = rd_en & ~empty & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/pifo_calendar_ctrl.sv
// Sequences enqueue inserts and dequeue pops onto the root PIFO calendar,
// one operation per cycle with round-robin arbitration, plus a drain flush.
module pifo_calendar_ctrl
    import pifo_calendar_ctrl_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH         = 12,
    parameter int PIFO_RANK_WIDTH           = ELEM_RANK_W,
    parameter int PIFO_ROOT_WIDTH           = 32,
    parameter int ROOT_RANK_START_POS       = ELEM_RANK_POS,
    parameter int ROOT_PIFO_INFO_VALID_POS  = ELEM_VALID_POS,
    parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
    parameter int ENQ_FIFO_DEPTH            = 4,
    parameter int STALL_CNT_WIDTH           = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 s_enq_valid,
    output logic                                 s_enq_ready,
    input  logic [PIFO_RANK_WIDTH-1:0]           s_enq_rank,
    input  logic [BUFFER_ADDR_WIDTH-1:0]         s_enq_addr,
    input  logic                                 s_deq_req,
    output logic                                 m_deq_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0]         m_deq_addr,
    output logic [PIFO_RANK_WIDTH-1:0]           m_deq_rank,
    input  logic                                 flush_start,
    output logic                                 flush_busy,
    output logic [PIFO_ROOT_WIDTH-1:0]           m_cal_info,
    output logic                                 m_cal_insert_en,
    output logic                                 m_cal_pop_en,
    input  logic [PIFO_ROOT_WIDTH-1:0]           s_cal_top,
    input  logic                                 s_cal_full,
    input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] s_cal_count,
    output logic [STALL_CNT_WIDTH-1:0]           stat_insert_stall_cnt
);

    localparam int FW = PIFO_RANK_WIDTH + BUFFER_ADDR_WIDTH;

    logic                         fifo_full;
    logic                         fifo_empty;
    logic [FW-1:0]                fifo_head;
    logic [ELEM_MAX_W-1:0]        elem;
    logic                         unused_bits;

    logic [0:0]                   state_q;
    logic [0:0]                   state_d;
    logic                         deq_pending_q;
    logic                         deq_pending_d;
    logic                         last_ins_q;
    logic                         last_ins_d;
    logic                         m_deq_valid_q;
    logic                         m_deq_valid_d;
    logic [BUFFER_ADDR_WIDTH-1:0] m_deq_addr_q;
    logic [BUFFER_ADDR_WIDTH-1:0] m_deq_addr_d;
    logic [PIFO_RANK_WIDTH-1:0]   m_deq_rank_q;
    logic [PIFO_RANK_WIDTH-1:0]   m_deq_rank_d;
    logic [STALL_CNT_WIDTH-1:0]   stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0]   stall_cnt_d;

    logic run;
    logic cal_nonempty;
    logic ins_elig;
    logic pop_elig;
    logic ins_gnt;
    logic pop_gnt;
    logic flush_go;

    pifo_ctrl_enq_fifo #(
        .WIDTH (FW),
        .DEPTH (ENQ_FIFO_DEPTH)
    ) u_enq_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (flush_go),
        .wr_en   (s_enq_valid),
        .wr_data ({s_enq_rank, s_enq_addr}),
        .rd_en   (ins_gnt),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign elem = pack_elem(
        {{(ELEM_MAX_W-PIFO_RANK_WIDTH){1'b0}}, fifo_head[FW-1 -: PIFO_RANK_WIDTH]},
        {{(ELEM_MAX_W-BUFFER_ADDR_WIDTH){1'b0}}, fifo_head[BUFFER_ADDR_WIDTH-1:0]},
        ROOT_RANK_START_POS, PIFO_RANK_WIDTH, BUFFER_ADDR_WIDTH,
        ROOT_PIFO_INFO_VALID_POS, ELEM_OVF_POS);

    assign unused_bits = ^{elem[ELEM_MAX_W-1:PIFO_ROOT_WIDTH], s_cal_top};

    assign m_cal_info            = elem[PIFO_ROOT_WIDTH-1:0];
    assign m_cal_insert_en       = ins_gnt;
    assign m_cal_pop_en          = pop_gnt;
    assign s_enq_ready           = ~fifo_full;
    assign flush_busy            = (state_q == ST_FLUSH);
    assign m_deq_valid           = m_deq_valid_q;
    assign m_deq_addr            = m_deq_addr_q;
    assign m_deq_rank            = m_deq_rank_q;
    assign stat_insert_stall_cnt = stall_cnt_q;

    // Flush drains whatever the calendar holds, ignoring egress requests.
    always_comb begin
        run          = (state_q == ST_RUN);
        cal_nonempty = (s_cal_count != '0);
        flush_go     = run & flush_start;
        ins_elig     = ~fifo_empty & ~s_cal_full & run;
        pop_elig     = cal_nonempty & (~run | s_deq_req | deq_pending_q);
        if (ins_elig & pop_elig) begin
            ins_gnt = ~last_ins_q;
            pop_gnt = last_ins_q;
        end else begin
            ins_gnt = ins_elig;
            pop_gnt = pop_elig;
        end
    end

    always_comb begin
        state_d       = state_q;
        deq_pending_d = deq_pending_q;
        last_ins_d    = last_ins_q;
        m_deq_valid_d = pop_gnt & run;
        m_deq_addr_d  = m_deq_addr_q;
        m_deq_rank_d  = m_deq_rank_q;
        stall_cnt_d   = stall_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (flush_start) state_d = ST_FLUSH;
            end
            default: begin
                if (!pop_gnt && !cal_nonempty) state_d = ST_RUN;
            end
        endcase

        if (flush_go || pop_gnt) begin
            deq_pending_d = 1'b0;
        end else if (run && s_deq_req) begin
            deq_pending_d = 1'b1;
        end

        if (ins_gnt) begin
            last_ins_d = 1'b1;
        end else if (pop_gnt) begin
            last_ins_d = 1'b0;
        end

        if (pop_gnt && run) begin
            m_deq_addr_d = s_cal_top[BUFFER_ADDR_WIDTH-1:0];
            m_deq_rank_d = s_cal_top[ROOT_RANK_START_POS +: PIFO_RANK_WIDTH];
        end

        if (~fifo_empty && s_cal_full && run && ~&stall_cnt_q) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // last_ins resets high so the first contended cycle goes to pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_RUN;
            deq_pending_q <= 1'b0;
            last_ins_q    <= 1'b1;
            m_deq_valid_q <= 1'b0;
            m_deq_addr_q  <= '0;
            m_deq_rank_q  <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            deq_pending_q <= deq_pending_d;
            last_ins_q    <= last_ins_d;
            m_deq_valid_q <= m_deq_valid_d;
            m_deq_addr_q  <= m_deq_addr_d;
            m_deq_rank_q  <= m_deq_rank_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// Bench for pifo_calendar_ctrl: sorted-queue calendar model, FIFO order
// model and directed plus randomized stimulus.
module tb_pifo_calendar_ctrl;

    localparam int AW = 12;
    localparam int RW = 18;
    localparam int EW = 32;
    localparam int CW = 10;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_enq_valid = 1'b0;
    logic          s_enq_ready;
    logic [RW-1:0] s_enq_rank = '0;
    logic [AW-1:0] s_enq_addr = '0;
    logic          s_deq_req = 1'b0;
    logic          m_deq_valid;
    logic [AW-1:0] m_deq_addr;
    logic [RW-1:0] m_deq_rank;
    logic          flush_start = 1'b0;
    logic          flush_busy;
    logic [EW-1:0] m_cal_info;
    logic          m_cal_insert_en;
    logic          m_cal_pop_en;
    logic [EW-1:0] s_cal_top = '0;
    logic          s_cal_full = 1'b0;
    logic [CW-1:0] s_cal_count = '0;
    logic [SW-1:0] stat_insert_stall_cnt;

    always #5 clk = ~clk;

    pifo_calendar_ctrl dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .s_enq_valid           (s_enq_valid),
        .s_enq_ready           (s_enq_ready),
        .s_enq_rank            (s_enq_rank),
        .s_enq_addr            (s_enq_addr),
        .s_deq_req             (s_deq_req),
        .m_deq_valid           (m_deq_valid),
        .m_deq_addr            (m_deq_addr),
        .m_deq_rank            (m_deq_rank),
        .flush_start           (flush_start),
        .flush_busy            (flush_busy),
        .m_cal_info            (m_cal_info),
        .m_cal_insert_en       (m_cal_insert_en),
        .m_cal_pop_en          (m_cal_pop_en),
        .s_cal_top             (s_cal_top),
        .s_cal_full            (s_cal_full),
        .s_cal_count           (s_cal_count),
        .stat_insert_stall_cnt (stat_insert_stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] cal_q[$];
    logic [EW-1:0] fifo_q[$];
    logic [AW-1:0] deq_log[$];

    bit in_flush = 1'b0;
    int both_err = 0;
    int bad_pop = 0;
    int bad_ins = 0;
    int rdy_err = 0;
    int deqv_err = 0;
    int flush_err = 0;
    int stall_exp = 0;
    int pop_cnt = 0;
    int ins_cnt = 0;
    int acc_cnt = 0;
    longint acc_sum = 0;
    bit last_ins = 1'b0;
    bit last_pop = 1'b0;
    bit last_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_elem(input logic [RW-1:0] r,
                                              input logic [AW-1:0] a);
        return {1'b1, 1'b0, r, a};
    endfunction

    task automatic cal_insert(input logic [EW-1:0] e);
        int i = 0;
        while (i < cal_q.size() && cal_q[i][29:12] <= e[29:12]) i++;
        cal_q.insert(i, e);
    endtask

    task automatic drive_cal();
        s_cal_count = CW'(cal_q.size());
        s_cal_top   = (cal_q.size() != 0) ? cal_q[0] : '0;
    endtask

    task automatic step();
        logic          ins;
        logic          pop;
        logic          rdy;
        logic          acc;
        logic [EW-1:0] info;
        logic [EW-1:0] top;
        bit            flush_old;
        bit            flush_new;
        bit            exp_v;
        @(negedge clk);
        ins  = m_cal_insert_en;
        pop  = m_cal_pop_en;
        info = m_cal_info;
        top  = s_cal_top;
        rdy  = s_enq_ready;
        acc  = s_enq_valid & rdy & rstn;
        if (ins && pop) both_err++;
        if (pop && cal_q.size() == 0) bad_pop++;
        if (ins && s_cal_full) bad_ins++;
        if (rdy !== (fifo_q.size() < 4)) rdy_err++;
        if (rstn && !in_flush && fifo_q.size() != 0 && s_cal_full &&
            stall_exp < 65535) stall_exp++;
        if (ins) begin
            if (fifo_q.size() == 0) begin
                bad_ins++;
            end else begin
                check("cal_info", info, fifo_q[0]);
                void'(fifo_q.pop_front());
            end
        end
        if (acc) begin
            fifo_q.push_back(mk_elem(s_enq_rank, s_enq_addr));
            acc_cnt++;
            acc_sum += s_enq_addr;
        end
        flush_old = in_flush;
        flush_new = in_flush;
        if (rstn) begin
            if (!in_flush && flush_start) begin
                flush_new = 1'b1;
                fifo_q.delete();
            end else if (in_flush && cal_q.size() == 0 && !pop) begin
                flush_new = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        in_flush = flush_new;
        exp_v = pop && !flush_old && rstn;
        if (m_deq_valid !== exp_v) deqv_err++;
        if (exp_v) begin
            check("deq_addr", m_deq_addr, top[11:0]);
            check("deq_rank", m_deq_rank, top[29:12]);
            deq_log.push_back(m_deq_addr);
        end
        if (flush_busy !== in_flush) flush_err++;
        if (pop && cal_q.size() != 0) void'(cal_q.pop_front());
        if (ins) cal_insert(info);
        pop_cnt += int'(pop);
        ins_cnt += int'(ins);
        last_ins = ins;
        last_pop = pop;
        last_acc = acc;
        drive_cal();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic enq(input logic [RW-1:0] r, input logic [AW-1:0] a);
        bit done = 1'b0;
        s_enq_valid = 1'b1;
        s_enq_rank  = r;
        s_enq_addr  = a;
        for (int k = 0; k < 50 && !done; k++) begin
            step();
            done = last_acc;
        end
        s_enq_valid = 1'b0;
        check("enq_accepted", done, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        s_enq_valid = 1'b0;
        s_cal_full  = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            s_deq_req = (cal_q.size() != 0);
            step();
            done = (cal_q.size() == 0) && (fifo_q.size() == 0);
        end
        s_deq_req = 1'b0;
        check("drain_done", done, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_log;
        int b_pop;
        int b_ins;
        int b_acc;
        longint b_sum;
        longint got_sum;
        int seq;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_enq_ready, 1);
        check("rst_deq_valid", m_deq_valid, 0);
        check("rst_deq_addr", m_deq_addr, 0);
        check("rst_deq_rank", m_deq_rank, 0);
        check("rst_flush_busy", flush_busy, 0);
        check("rst_stall", stat_insert_stall_cnt, 0);
        check("rst_ins_en", m_cal_insert_en, 0);
        check("rst_pop_en", m_cal_pop_en, 0);
        rstn = 1'b1;
        idle(2);

        enq(5, 12'h010);
        enq(2, 12'h011);
        enq(9, 12'h012);
        idle(4);
        check("t1_count3", s_cal_count, 3);
        b_log = deq_log.size();
        for (int k = 0; k < 3; k++) begin
            s_deq_req = 1'b1;
            step();
            s_deq_req = 1'b0;
            step();
        end
        check("t1_ndeq", deq_log.size() - b_log, 3);
        if (deq_log.size() - b_log == 3) begin
            check("t1_addr0", deq_log[b_log], 12'h011);
            check("t1_addr1", deq_log[b_log+1], 12'h010);
            check("t1_addr2", deq_log[b_log+2], 12'h012);
        end
        check("t1_count0", cal_q.size(), 0);

        b_pop = pop_cnt;
        s_deq_req = 1'b1;
        step();
        s_deq_req = 1'b0;
        check("t2_nopop_empty", pop_cnt - b_pop, 0);
        enq(7, 12'h020);
        idle(5);
        check("t2_pending_pop", pop_cnt - b_pop, 1);
        check("t2_addr", deq_log[deq_log.size()-1], 12'h020);

        enq(40, 12'h030);
        enq(41, 12'h031);
        idle(3);
        check("t3_count2", s_cal_count, 2);

        s_cal_full = 1'b1;
        b_ins = ins_cnt;
        enq(3, 12'h040);
        enq(1, 12'h041);
        enq(8, 12'h042);
        enq(6, 12'h043);
        idle(7);
        check("t4_stall10", stat_insert_stall_cnt, 10);
        check("t4_ready0", s_enq_ready, 0);
        check("t4_noins", ins_cnt - b_ins, 0);

        s_cal_full = 1'b0;
        s_deq_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("alt%0d", k), {last_ins, last_pop},
                  (k % 2 == 0) ? 64'h1 : 64'h2);
        end
        s_deq_req = 1'b0;
        drain();

        for (int k = 0; k < 5; k++) enq(RW'(10 + k), AW'(12'h050 + k));
        idle(6);
        check("t5_count5", s_cal_count, 5);
        s_cal_full = 1'b1;
        enq(0, 12'h060);
        enq(0, 12'h061);
        b_pop = pop_cnt;
        b_log = deq_log.size();
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        check("t5_busy", flush_busy, 1);
        for (int k = 0; k < 40 && flush_busy; k++) step();
        check("t5_busy_fall", flush_busy, 0);
        check("t5_pops5", pop_cnt - b_pop, 5);
        check("t5_no_deq", deq_log.size() - b_log, 0);
        check("t5_cal_empty", cal_q.size(), 0);
        s_cal_full = 1'b0;
        b_ins = ins_cnt;
        idle(5);
        check("t5_fifo_cleared", ins_cnt - b_ins, 0);
        check("t5_ready", s_enq_ready, 1);

        enq(20, 12'h070);
        enq(21, 12'h071);
        enq(22, 12'h072);
        idle(4);
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        step();
        check("t6_busy", flush_busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_busy", flush_busy, 0);
        check("t6_rst_deq_valid", m_deq_valid, 0);
        fifo_q.delete();
        in_flush  = 1'b0;
        stall_exp = 0;
        idle(2);
        rstn  = 1'b1;
        b_pop = pop_cnt;
        idle(5);
        check("t6_run_nopop", pop_cnt - b_pop, 0);
        check("t6_run_busy", flush_busy, 0);
        check("t6_cal_left", s_cal_count, 2);
        drain();

        b_acc = acc_cnt;
        b_sum = acc_sum;
        b_log = deq_log.size();
        seq   = 256;
        for (int k = 0; k < 400; k++) begin
            s_enq_valid = ($urandom_range(0, 1) == 1);
            s_enq_rank  = RW'($urandom_range(0, 63));
            s_enq_addr  = AW'(seq);
            s_deq_req   = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) == 0) s_cal_full = ~s_cal_full;
            step();
            seq++;
        end
        drain();
        got_sum = 0;
        for (int k = b_log; k < deq_log.size(); k++) got_sum += deq_log[k];
        check("rnd_ndeq", deq_log.size() - b_log, acc_cnt - b_acc);
        check("rnd_addr_sum", got_sum, acc_sum - b_sum);

        check("inv_both_strobes", both_err, 0);
        check("inv_pop_empty", bad_pop, 0);
        check("inv_bad_insert", bad_ins, 0);
        check("inv_ready", rdy_err, 0);
        check("inv_deq_valid", deqv_err, 0);
        check("inv_flush_busy", flush_err, 0);
        check("stall_model", stat_insert_stall_cnt, stall_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
